// File: rtl/rtc_pkg.sv
// Shared field limits, field type and the month-length helper for the RTC calendar.
package rtc_pkg;

  typedef logic [7:0] field_t;

  localparam int unsigned SecLimit   = 60;
  localparam int unsigned MinLimit   = 60;
  localparam int unsigned HourLimit  = 24;
  localparam int unsigned MonthLimit = 12;
  localparam int unsigned WdayLimit  = 7;

  // Year 0 is 2000, so a plain mod-4 test is exact over the whole 0..99 range.
  function automatic field_t days_in_month(input field_t month, input field_t year);
    field_t days;
    case (month)
      8'd4, 8'd6, 8'd9, 8'd11: days = 8'd30;
      8'd2:                    days = ((year % 8'd4) == 8'd0) ? 8'd29 : 8'd28;
      default:                 days = 8'd31;
    endcase
    return days;
  endfunction

endpackage

// File: rtl/rtc_calendar_if.sv
// Load handshake for the RTC calendar: set_* values in, one-cycle ack/err pulses out.
interface rtc_calendar_if;
  import rtc_pkg::*;

  logic       set_valid;
  field_t     set_year;
  field_t     set_month;
  field_t     set_day;
  field_t     set_hour;
  field_t     set_minute;
  field_t     set_second;
  logic [2:0] set_wday;
  logic       set_ack;
  logic       set_err;

  modport master (
    output set_valid, set_year, set_month, set_day, set_hour, set_minute, set_second, set_wday,
    input  set_ack, set_err
  );

  modport slave (
    input  set_valid, set_year, set_month, set_day, set_hour, set_minute, set_second, set_wday,
    output set_ack, set_err
  );

endinterface

// File: rtl/rtc_bin2bcd.sv
// 8-bit binary to two-digit packed BCD; inputs are calendar fields, always below 100.
module rtc_bin2bcd
  import rtc_pkg::*;
(
  input  field_t bin,
  output field_t bcd
);

  logic [3:0] tens;
  logic [3:0] units;

  always_comb begin
    tens  = 4'(bin / 8'd10);
    units = 4'(bin % 8'd10);
    bcd   = {tens, units};
  end

endmodule

// File: rtl/rtc_calendar.sv
// 1 Hz real-time clock/calendar with validated load and optional BCD outputs.
// Defining RTC_ALARM_EN adds a sticky time-of-day alarm with its ports.
module rtc_calendar
  import rtc_pkg::*;
#(
  parameter int unsigned YEAR_MAX = 99,
  parameter int unsigned BCD_OUT  = 0
) (
  input  logic                 clk_1Hz,
  input  logic                 rst,
  input  logic                 en,
  rtc_calendar_if.slave        ld,
`ifdef RTC_ALARM_EN
  input  logic                 alm_set,
  input  field_t               alm_hour,
  input  field_t               alm_minute,
  input  field_t               alm_second,
  input  logic                 alm_clr,
  output logic                 alarm,
`endif
  output field_t               year,
  output field_t               month,
  output field_t               day,
  output field_t               hour,
  output field_t               minute,
  output field_t               second,
  output logic [2:0]           wday,
  output logic                 day_tick
);

  localparam field_t     YearMax = field_t'(YEAR_MAX);
  localparam field_t     SecMax  = field_t'(SecLimit - 1);
  localparam field_t     MinMax  = field_t'(MinLimit - 1);
  localparam field_t     HourMax = field_t'(HourLimit - 1);
  localparam field_t     MonMax  = field_t'(MonthLimit);
  localparam logic [2:0] WdayMax = 3'(WdayLimit - 1);

  field_t     year_q, month_q, day_q, hour_q, minute_q, second_q;
  field_t     year_d, month_d, day_d, hour_d, minute_d, second_d;
  logic [2:0] wday_q, wday_d;
  logic       set_ack_q, set_ack_d;
  logic       set_err_q, set_err_d;
  logic       day_tick_q, day_tick_d;

  logic sec_wrap, min_wrap, hour_wrap, day_wrap, month_wrap;
  logic load_ok;

  // Carries are chained combinationally so a full year rollover lands in one edge.
  always_comb begin
    sec_wrap   = (second_q == SecMax);
    min_wrap   = sec_wrap && (minute_q == MinMax);
    hour_wrap  = min_wrap && (hour_q == HourMax);
    day_wrap   = hour_wrap && (day_q == days_in_month(month_q, year_q));
    month_wrap = day_wrap && (month_q == MonMax);
  end

  always_comb begin
    load_ok = (ld.set_month >= 8'd1) && (ld.set_month <= MonMax) &&
              (ld.set_day >= 8'd1) &&
              (ld.set_day <= days_in_month(ld.set_month, ld.set_year)) &&
              (ld.set_hour < field_t'(HourLimit)) &&
              (ld.set_minute < field_t'(MinLimit)) &&
              (ld.set_second < field_t'(SecLimit)) &&
              (ld.set_year <= YearMax) &&
              (ld.set_wday <= WdayMax);
  end

  always_comb begin
    year_d     = year_q;
    month_d    = month_q;
    day_d      = day_q;
    hour_d     = hour_q;
    minute_d   = minute_q;
    second_d   = second_q;
    wday_d     = wday_q;
    set_ack_d  = 1'b0;
    set_err_d  = 1'b0;
    day_tick_d = 1'b0;

    // A load edge never counts a second, whether the load is accepted or not.
    if (ld.set_valid) begin
      if (load_ok) begin
        year_d    = ld.set_year;
        month_d   = ld.set_month;
        day_d     = ld.set_day;
        hour_d    = ld.set_hour;
        minute_d  = ld.set_minute;
        second_d  = ld.set_second;
        wday_d    = ld.set_wday;
        set_ack_d = 1'b1;
      end else begin
        set_err_d = 1'b1;
      end
    end else if (en) begin
      second_d = sec_wrap ? 8'd0 : second_q + 8'd1;
      if (sec_wrap) begin
        minute_d = min_wrap ? 8'd0 : minute_q + 8'd1;
      end
      if (min_wrap) begin
        hour_d = hour_wrap ? 8'd0 : hour_q + 8'd1;
      end
      if (hour_wrap) begin
        day_d      = day_wrap ? 8'd1 : day_q + 8'd1;
        wday_d     = (wday_q == WdayMax) ? 3'd0 : wday_q + 3'd1;
        day_tick_d = 1'b1;
      end
      if (day_wrap) begin
        month_d = month_wrap ? 8'd1 : month_q + 8'd1;
      end
      if (month_wrap) begin
        year_d = (year_q >= YearMax) ? 8'd0 : year_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_1Hz or negedge rst) begin
    if (!rst) begin
      year_q     <= 8'd0;
      month_q    <= 8'd1;
      day_q      <= 8'd1;
      hour_q     <= 8'd0;
      minute_q   <= 8'd0;
      second_q   <= 8'd0;
      wday_q     <= 3'd0;
      set_ack_q  <= 1'b0;
      set_err_q  <= 1'b0;
      day_tick_q <= 1'b0;
    end else begin
      year_q     <= year_d;
      month_q    <= month_d;
      day_q      <= day_d;
      hour_q     <= hour_d;
      minute_q   <= minute_d;
      second_q   <= second_d;
      wday_q     <= wday_d;
      set_ack_q  <= set_ack_d;
      set_err_q  <= set_err_d;
      day_tick_q <= day_tick_d;
    end
  end

  assign ld.set_ack = set_ack_q;
  assign ld.set_err = set_err_q;
  assign day_tick   = day_tick_q;

`ifdef RTC_ALARM_EN
  field_t alm_hour_q, alm_minute_q, alm_second_q;
  logic   alarm_q, alarm_d;
  logic   time_upd;

  // Match against the time being written this edge, so a hold with en low never re-arms.
  always_comb begin
    time_upd = ld.set_valid ? load_ok : en;
    alarm_d  = alarm_q;
    if (alm_clr) begin
      alarm_d = 1'b0;
    end else if (time_upd && (hour_d == alm_hour_q) && (minute_d == alm_minute_q) &&
                 (second_d == alm_second_q)) begin
      alarm_d = 1'b1;
    end
  end

  always_ff @(posedge clk_1Hz or negedge rst) begin
    if (!rst) begin
      alm_hour_q   <= 8'd0;
      alm_minute_q <= 8'd0;
      alm_second_q <= 8'd0;
      alarm_q      <= 1'b0;
    end else begin
      if (alm_set) begin
        alm_hour_q   <= alm_hour;
        alm_minute_q <= alm_minute;
        alm_second_q <= alm_second;
      end
      alarm_q <= alarm_d;
    end
  end

  assign alarm = alarm_q;
`endif

  if (BCD_OUT != 0) begin : g_bcd
    rtc_bin2bcd u_year   (.bin(year_q),   .bcd(year));
    rtc_bin2bcd u_month  (.bin(month_q),  .bcd(month));
    rtc_bin2bcd u_day    (.bin(day_q),    .bcd(day));
    rtc_bin2bcd u_hour   (.bin(hour_q),   .bcd(hour));
    rtc_bin2bcd u_minute (.bin(minute_q), .bcd(minute));
    rtc_bin2bcd u_second (.bin(second_q), .bcd(second));
  end else begin : g_bin
    assign year   = year_q;
    assign month  = month_q;
    assign day    = day_q;
    assign hour   = hour_q;
    assign minute = minute_q;
    assign second = second_q;
  end

  // Weekday is 0..6, already identical in binary and BCD.
  assign wday = wday_q;

  ack_err_exclusive: assert property (@(posedge clk_1Hz) disable iff (!rst)
                                      !(set_ack_q && set_err_q));

endmodule

// File: tb/tb_rtc_calendar.sv
// Directed table-driven bench for rtc_calendar (binary and BCD instances); alarm under RTC_ALARM_EN.
module tb_rtc_calendar;
  import rtc_pkg::*;

  logic clk_1Hz;
  logic rst;
  logic en;

  rtc_calendar_if ifb ();
  rtc_calendar_if ifc ();

  field_t     b_year, b_month, b_day, b_hour, b_minute, b_second;
  field_t     c_year, c_month, c_day, c_hour, c_minute, c_second;
  logic [2:0] b_wday, c_wday;
  logic       b_day_tick, c_day_tick;

`ifdef RTC_ALARM_EN
  logic   alm_set, alm_clr, alarm_b, alarm_c;
  field_t alm_hour, alm_minute, alm_second;
`endif

  rtc_calendar #(.YEAR_MAX(99), .BCD_OUT(0)) u_bin (
    .clk_1Hz    (clk_1Hz),
    .rst        (rst),
    .en         (en),
    .ld         (ifb),
`ifdef RTC_ALARM_EN
    .alm_set    (alm_set),
    .alm_hour   (alm_hour),
    .alm_minute (alm_minute),
    .alm_second (alm_second),
    .alm_clr    (alm_clr),
    .alarm      (alarm_b),
`endif
    .year       (b_year),
    .month      (b_month),
    .day        (b_day),
    .hour       (b_hour),
    .minute     (b_minute),
    .second     (b_second),
    .wday       (b_wday),
    .day_tick   (b_day_tick)
  );

  rtc_calendar #(.YEAR_MAX(99), .BCD_OUT(1)) u_bcd (
    .clk_1Hz    (clk_1Hz),
    .rst        (rst),
    .en         (en),
    .ld         (ifc),
`ifdef RTC_ALARM_EN
    .alm_set    (alm_set),
    .alm_hour   (alm_hour),
    .alm_minute (alm_minute),
    .alm_second (alm_second),
    .alm_clr    (alm_clr),
    .alarm      (alarm_c),
`endif
    .year       (c_year),
    .month      (c_month),
    .day        (c_day),
    .hour       (c_hour),
    .minute     (c_minute),
    .second     (c_second),
    .wday       (c_wday),
    .day_tick   (c_day_tick)
  );

  initial begin
    clk_1Hz = 1'b0;
    forever #5 clk_1Hz = ~clk_1Hz;
  end

  typedef struct {
    logic       sv;
    logic       en;
    field_t     y, mo, d, h, mi, s;
    logic [2:0] wd;
    field_t     ey, emo, ed, eh, emi, es;
    logic [2:0] ewd;
    logic       eack, eerr, etick;
  } vec_t;

  localparam int NumVec = 24;
  vec_t vecs [NumVec];

  int vectors     = 0;
  int miscompares = 0;

  function automatic vec_t mk(input int sv, input int en_v,
                              input int y, input int mo, input int d,
                              input int h, input int mi, input int s, input int wd,
                              input int ey, input int emo, input int ed,
                              input int eh, input int emi, input int es, input int ewd,
                              input int eack, input int eerr, input int etick);
    vec_t v;
    v.sv = sv[0];   v.en = en_v[0];
    v.y = 8'(y);    v.mo = 8'(mo);   v.d = 8'(d);
    v.h = 8'(h);    v.mi = 8'(mi);   v.s = 8'(s);   v.wd = 3'(wd);
    v.ey = 8'(ey);  v.emo = 8'(emo); v.ed = 8'(ed);
    v.eh = 8'(eh);  v.emi = 8'(emi); v.es = 8'(es); v.ewd = 3'(ewd);
    v.eack = eack[0]; v.eerr = eerr[0]; v.etick = etick[0];
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_time(input string name, input int y, input int mo, input int d,
                            input int h, input int mi, input int s, input int wd);
    check(name, {8'h0, b_year, b_month, b_day, b_hour, b_minute, b_second, 5'd0, b_wday},
          {8'h0, 8'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s), 5'd0, 3'(wd)});
  endtask

  task automatic check_flags(input string name, input int ack, input int err, input int tick);
    check(name, {61'd0, ifb.set_ack, ifb.set_err, b_day_tick},
          {61'd0, ack[0], err[0], tick[0]});
  endtask

  task automatic drive(input int sv, input int en_v, input int y, input int mo, input int d,
                       input int h, input int mi, input int s, input int wd);
    en             = en_v[0];
    ifb.set_valid  = sv[0];       ifc.set_valid  = sv[0];
    ifb.set_year   = 8'(y);       ifc.set_year   = 8'(y);
    ifb.set_month  = 8'(mo);      ifc.set_month  = 8'(mo);
    ifb.set_day    = 8'(d);       ifc.set_day    = 8'(d);
    ifb.set_hour   = 8'(h);       ifc.set_hour   = 8'(h);
    ifb.set_minute = 8'(mi);      ifc.set_minute = 8'(mi);
    ifb.set_second = 8'(s);       ifc.set_second = 8'(s);
    ifb.set_wday   = 3'(wd);      ifc.set_wday   = 3'(wd);
  endtask

  task automatic edge_step();
    @(posedge clk_1Hz);
    @(negedge clk_1Hz);
  endtask

  initial begin
    //            sv en  y  mo  d  h  mi  s wd    ey emo ed eh emi es ewd ack err tick
    vecs[0]  = mk(0, 1,  0, 0, 0, 0, 0, 0, 0,    0, 1, 1,  0, 0, 1, 0,  0, 0, 0);
    vecs[1]  = mk(1, 1, 23,12,31,23,59,59, 6,   23,12,31, 23,59,59, 6,  1, 0, 0);
    vecs[2]  = mk(0, 1,  0, 0, 0, 0, 0, 0, 0,   24, 1, 1,  0, 0, 0, 0,  0, 0, 1);
    vecs[3]  = mk(1, 1, 24, 2,28,23,59,59, 3,   24, 2,28, 23,59,59, 3,  1, 0, 0);
    vecs[4]  = mk(0, 1,  0, 0, 0, 0, 0, 0, 0,   24, 2,29,  0, 0, 0, 4,  0, 0, 1);
    vecs[5]  = mk(1, 1, 23, 2,28,23,59,59, 2,   23, 2,28, 23,59,59, 2,  1, 0, 0);
    vecs[6]  = mk(0, 1,  0, 0, 0, 0, 0, 0, 0,   23, 3, 1,  0, 0, 0, 3,  0, 0, 1);
    vecs[7]  = mk(1, 1, 23,13, 1, 0, 0, 0, 0,   23, 3, 1,  0, 0, 0, 3,  0, 1, 0);
    vecs[8]  = mk(1, 1, 23, 4,31, 0, 0, 0, 0,   23, 3, 1,  0, 0, 0, 3,  0, 1, 0);
    vecs[9]  = mk(0, 1,  0, 0, 0, 0, 0, 0, 0,   23, 3, 1,  0, 0, 1, 3,  0, 0, 0);
    vecs[10] = mk(1, 1, 99,12,31,23,59,59, 5,   99,12,31, 23,59,59, 5,  1, 0, 0);
    vecs[11] = mk(0, 1,  0, 0, 0, 0, 0, 0, 0,    0, 1, 1,  0, 0, 0, 6,  0, 0, 1);
    vecs[12] = mk(1, 1,  0, 1, 1,24, 0, 0, 0,    0, 1, 1,  0, 0, 0, 6,  0, 1, 0);
    vecs[13] = mk(0, 0,  0, 0, 0, 0, 0, 0, 0,    0, 1, 1,  0, 0, 0, 6,  0, 0, 0);
    vecs[14] = mk(1, 0, 10, 6,15,12,34,56, 1,   10, 6,15, 12,34,56, 1,  1, 0, 0);
    vecs[15] = mk(0, 1,  0, 0, 0, 0, 0, 0, 0,   10, 6,15, 12,34,57, 1,  0, 0, 0);
    vecs[16] = mk(1, 1, 23, 2,29, 0, 0, 0, 0,   10, 6,15, 12,34,57, 1,  0, 1, 0);
    vecs[17] = mk(1, 1, 10, 6,15,12,60, 0, 1,   10, 6,15, 12,34,57, 1,  0, 1, 0);
    vecs[18] = mk(1, 1, 10, 6,30,12,59,59, 1,   10, 6,30, 12,59,59, 1,  1, 0, 0);
    vecs[19] = mk(0, 1,  0, 0, 0, 0, 0, 0, 0,   10, 6,30, 13, 0, 0, 1,  0, 0, 0);
    vecs[20] = mk(1, 1, 10, 6,30, 0, 0, 0, 7,   10, 6,30, 13, 0, 0, 1,  0, 1, 0);
    vecs[21] = mk(0, 1,  0, 0, 0, 0, 0, 0, 0,   10, 6,30, 13, 0, 1, 1,  0, 0, 0);
    vecs[22] = mk(1, 1, 10,11,30,23,59,59, 0,   10,11,30, 23,59,59, 0,  1, 0, 0);
    vecs[23] = mk(0, 1,  0, 0, 0, 0, 0, 0, 0,   10,12, 1,  0, 0, 0, 1,  0, 0, 1);

`ifdef RTC_ALARM_EN
    alm_set = 1'b0; alm_clr = 1'b0; alm_hour = 8'd0; alm_minute = 8'd0; alm_second = 8'd0;
`endif
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    @(negedge clk_1Hz);
    check_time("reset_time", 0, 1, 1, 0, 0, 0, 0);
    check_flags("reset_flags", 0, 0, 0);
    rst = 1'b1;

    for (int i = 0; i < NumVec; i++) begin
      drive(vecs[i].sv, vecs[i].en, vecs[i].y, vecs[i].mo, vecs[i].d, vecs[i].h, vecs[i].mi,
            vecs[i].s, vecs[i].wd);
      edge_step();
      check($sformatf("vec%0d_time", i),
            {8'h0, b_year, b_month, b_day, b_hour, b_minute, b_second, 5'd0, b_wday},
            {8'h0, vecs[i].ey, vecs[i].emo, vecs[i].ed, vecs[i].eh, vecs[i].emi, vecs[i].es,
             5'd0, vecs[i].ewd});
      check($sformatf("vec%0d_flags", i), {61'd0, ifb.set_ack, ifb.set_err, b_day_tick},
            {61'd0, vecs[i].eack, vecs[i].eerr, vecs[i].etick});
    end

    // BCD encoding of a freshly loaded time, then en low holds for five edges.
    drive(1, 1, 23, 12, 31, 23, 59, 45, 2);
    edge_step();
    check("bcd_date", {40'd0, c_year, c_month, c_day}, {40'd0, 8'h23, 8'h12, 8'h31});
    check("bcd_time", {40'd0, c_hour, c_minute, c_second}, {40'd0, 8'h23, 8'h59, 8'h45});
    check("bcd_ack", {63'd0, ifc.set_ack}, 64'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      edge_step();
      check_time($sformatf("frozen%0d", k), 23, 12, 31, 23, 59, 45, 2);
    end
    check_flags("frozen_flags", 0, 0, 0);
    en = 1'b1;
    edge_step();
    check_time("resume", 23, 12, 31, 23, 59, 46, 2);
    check("bcd_resume", {56'd0, c_second}, {56'd0, 8'h46});

    // Reset asserted between the load request and its edge: no ack, fields at reset values.
    drive(1, 1, 5, 5, 5, 5, 5, 5, 5);
    #2 rst = 1'b0;
    edge_step();
    check_time("abort_time", 0, 1, 1, 0, 0, 0, 0);
    check_flags("abort_flags", 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    edge_step();
    check_time("first_count", 0, 1, 1, 0, 0, 1, 0);

`ifdef RTC_ALARM_EN
    rst = 1'b0;
    #2 rst = 1'b1;
    en = 1'b0;
    alm_set = 1'b1; alm_hour = 8'd0; alm_minute = 8'd0; alm_second = 8'd5;
    edge_step();
    alm_set = 1'b0;
    en = 1'b1;
    repeat (4) edge_step();
    check("alarm_early", {63'd0, alarm_b}, 64'd0);
    edge_step();
    check_time("alarm_time", 0, 1, 1, 0, 0, 5, 0);
    check("alarm_hit", {63'd0, alarm_b}, 64'd1);
    repeat (2) edge_step();
    check("alarm_sticky", {63'd0, alarm_b}, 64'd1);
    alm_clr = 1'b1;
    edge_step();
    alm_clr = 1'b0;
    check("alarm_clr", {63'd0, alarm_b}, 64'd0);
    repeat (3) edge_step();
    rst = 1'b0;
    #1;
    check_time("alarm_midreset", 0, 1, 1, 0, 0, 0, 0);
    check("alarm_reset", {63'd0, alarm_b}, 64'd0);
    rst = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
